// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - single-outstanding instruction fetch unit with one-entry instruction buffer
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect enters TRAP instead of being truncated)
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    input  logic        halt_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        halted,
    output logic        trap,
    output logic [31:0] trap_pc
);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_HALT,
        ST_TRAP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] trap_pc_q, trap_pc_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_data_q  <= 32'h0;
            inst_pc_q    <= 32'h0;
            trap_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
            trap_pc_q    <= trap_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;
        trap_pc_d    = trap_pc_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    inst_data_d  = imem_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Redirect/halt inputs are only meaningful in the consume cycle.
                if (inst_valid_q && inst_ready) begin
                    inst_valid_d = 1'b0;
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (pc_src) begin
`ifdef PC_MISALIGN_TRAP_EN
                        if (pc_target[1:0] != 2'b00) begin
                            state_d   = ST_TRAP;
                            trap_pc_d = pc_target;
                        end else begin
                            pc_d    = pc_target;
                            state_d = ST_FETCH;
                        end
`else
                        pc_d    = pc_target & ~32'h3;
                        state_d = ST_FETCH;
`endif
                    end else begin
                        pc_d    = inst_pc_q + 32'd4;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT, ST_TRAP: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Gating with rst_n keeps the request low during the reset cycle itself.
    assign imem_req   = rst_n && (state_q == ST_FETCH);
    assign imem_addr  = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst_data  = inst_data_q;
    assign inst_pc    = inst_pc_q;
    assign halted     = (state_q == ST_HALT);
    assign trap       = (state_q == ST_TRAP);
    assign trap_pc    = trap_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed vector bench for pc_fetch_unit
module tb_pc_fetch_unit;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] Z = 32'h0;
    localparam logic [31:0] D = 32'h0050_0093;
    localparam logic [31:0] E = 32'hDEAD_BEEF;
    localparam logic [31:0] HI = 32'h0010_0073;
    localparam logic [31:0] TOP = 32'hFFFF_FFFC;

    typedef struct {
        logic        rst_n, gnt, rvalid;
        logic [31:0] rdata;
        logic        ready, src;
        logic [31:0] tgt;
        logic        halt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_data;
        logic        e_halted, e_trap;
        logic [31:0] e_trap_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, pc_src, halt_req, imem_gnt, imem_rvalid, inst_ready;
    logic [31:0] pc_target, imem_rdata;
    logic        imem_req, inst_valid, halted, trap;
    logic [31:0] imem_addr, inst_data, inst_pc, trap_pc;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl [19];

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .pc_target(pc_target),
        .halt_req(halt_req), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .halted(halted), .trap(trap), .trap_pc(trap_pc)
    );

    function automatic vec_t v(
        input logic rst, gnt, rv, input logic [31:0] rdata,
        input logic rdy, src, input logic [31:0] tgt, input logic hlt,
        input logic req, input logic [31:0] addr, input logic val,
        input logic [31:0] pc, data, input logic eh, et, input logic [31:0] tpc);
        vec_t r;
        r.rst_n = rst; r.gnt = gnt; r.rvalid = rv; r.rdata = rdata;
        r.ready = rdy; r.src = src; r.tgt = tgt; r.halt = hlt;
        r.e_req = req; r.e_addr = addr; r.e_valid = val; r.e_pc = pc;
        r.e_data = data; r.e_halted = eh; r.e_trap = et; r.e_trap_pc = tpc;
        return r;
    endfunction

    task automatic apply(input vec_t t, input string name);
        logic [131:0] act, exp;
        @(negedge clk);
        rst_n = t.rst_n; imem_gnt = t.gnt; imem_rvalid = t.rvalid; imem_rdata = t.rdata;
        inst_ready = t.ready; pc_src = t.src; pc_target = t.tgt; halt_req = t.halt;
        #1;
        act = {imem_req, imem_addr, inst_valid, inst_pc, inst_data, halted, trap, trap_pc};
        exp = {t.e_req, t.e_addr, t.e_valid, t.e_pc, t.e_data, t.e_halted, t.e_trap, t.e_trap_pc};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got req=%b addr=%h val=%b pc=%h data=%h halted=%b trap=%b tpc=%h, want req=%b addr=%h val=%b pc=%h data=%h halted=%b trap=%b tpc=%h",
                     name, imem_req, imem_addr, inst_valid, inst_pc, inst_data, halted, trap, trap_pc,
                     t.e_req, t.e_addr, t.e_valid, t.e_pc, t.e_data, t.e_halted, t.e_trap, t.e_trap_pc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = Z;
        inst_ready = 1'b0; pc_src = 1'b0; pc_target = Z; halt_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Sequential fetch 0,4,8 plus stall, ignored rvalid, and a 5-cycle decode backpressure.
        tbl[0]  = v(L,L,L,Z,L,L,Z,L,          L,Z,L,Z,Z,L,L,Z);
        tbl[1]  = v(H,H,L,Z,L,L,Z,L,          H,Z,L,Z,Z,L,L,Z);
        tbl[2]  = v(H,L,H,D,H,L,Z,L,          L,Z,L,Z,Z,L,L,Z);
        tbl[3]  = v(H,L,L,Z,H,L,Z,L,          L,Z,H,Z,D,L,L,Z);
        tbl[4]  = v(H,H,L,Z,L,L,Z,L,          H,32'h4,L,Z,D,L,L,Z);
        tbl[5]  = v(H,L,H,D,L,L,Z,L,          L,32'h4,L,Z,D,L,L,Z);
        tbl[6]  = v(H,L,L,Z,H,L,Z,L,          L,32'h4,H,32'h4,D,L,L,Z);
        tbl[7]  = v(H,L,L,Z,L,L,Z,L,          H,32'h8,L,32'h4,D,L,L,Z);
        tbl[8]  = v(H,L,H,E,L,L,Z,L,          H,32'h8,L,32'h4,D,L,L,Z);
        tbl[9]  = v(H,H,L,Z,L,L,Z,L,          H,32'h8,L,32'h4,D,L,L,Z);
        tbl[10] = v(H,L,L,Z,L,L,Z,L,          L,32'h8,L,32'h4,D,L,L,Z);
        tbl[11] = v(H,L,H,E,L,L,Z,L,          L,32'h8,L,32'h4,D,L,L,Z);
        for (int i = 12; i <= 16; i++)
            tbl[i] = v(H,L,L,Z,L,H,32'h100,H, L,32'h8,H,32'h8,E,L,L,Z);
        tbl[17] = v(H,L,L,Z,H,L,Z,L,          L,32'h8,H,32'h8,E,L,L,Z);
        tbl[18] = v(H,H,L,Z,L,L,Z,L,          H,32'hC,L,32'h8,E,L,L,Z);

        do_reset();
        for (int i = 0; i < 19; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Redirect 0x10 -> 0x40, then misaligned redirect to 0x42.
        apply(v(H,L,H,32'h1,L,L,Z,L,         L,32'hC,L,32'h8,E,L,L,Z), "redir_a1");
        apply(v(H,L,L,Z,H,H,32'h10,L,        L,32'hC,H,32'hC,32'h1,L,L,Z), "redir_a2");
        apply(v(H,H,L,Z,L,L,Z,L,             H,32'h10,L,32'hC,32'h1,L,L,Z), "redir_a3");
        apply(v(H,L,H,32'h2,L,L,Z,L,         L,32'h10,L,32'hC,32'h1,L,L,Z), "redir_a4");
        apply(v(H,L,L,Z,H,H,32'h40,L,        L,32'h10,H,32'h10,32'h2,L,L,Z), "redir_a5");
        apply(v(H,H,L,Z,L,L,Z,L,             H,32'h40,L,32'h10,32'h2,L,L,Z), "redir_no14");
        apply(v(H,L,H,32'h3,L,L,Z,L,         L,32'h40,L,32'h10,32'h2,L,L,Z), "redir_a7");
        apply(v(H,L,L,Z,H,H,32'h42,L,        L,32'h40,H,32'h40,32'h3,L,L,Z), "misalign_hs");
`ifdef PC_MISALIGN_TRAP_EN
        apply(v(H,H,L,Z,L,L,Z,L,             L,32'h40,L,32'h40,32'h3,L,H,32'h42), "misalign_trap");
`else
        apply(v(H,H,L,Z,L,L,Z,L,             H,32'h40,L,32'h40,32'h3,L,L,Z), "misalign_trunc");
`endif

        // Reset while WAIT; late rvalid must be dropped.
        do_reset();
        apply(v(H,H,L,Z,L,L,Z,L,             H,Z,L,Z,Z,L,L,Z), "rstwait_gnt");
        apply(v(L,L,L,Z,L,L,Z,L,             L,Z,L,Z,Z,L,L,Z), "rstwait_rst");
        apply(v(H,L,H,32'hBAD0BAD0,L,L,Z,L,  H,Z,L,Z,Z,L,L,Z), "rstwait_late_rv");
        apply(v(H,L,L,Z,L,L,Z,L,             H,Z,L,Z,Z,L,L,Z), "rstwait_after");

        // Halt has priority over a concurrent redirect and is terminal.
        apply(v(H,H,L,Z,L,L,Z,L,             H,Z,L,Z,Z,L,L,Z), "halt_gnt");
        apply(v(H,L,H,HI,L,L,Z,L,            L,Z,L,Z,Z,L,L,Z), "halt_rv");
        apply(v(H,L,L,Z,H,H,32'h80,H,        L,Z,H,Z,HI,L,L,Z), "halt_hs");
        for (int i = 0; i < 4; i++)
            apply(v(H,H,H,E,H,H,32'h80,L,    L,Z,L,Z,HI,H,L,Z), $sformatf("halt_stay%0d", i));

        // PC+4 wraps at the top of the address space; self-loop redirect does not halt.
        do_reset();
        apply(v(H,H,L,Z,L,L,Z,L,             H,Z,L,Z,Z,L,L,Z), "wrap_w1");
        apply(v(H,L,H,32'h5,L,L,Z,L,         L,Z,L,Z,Z,L,L,Z), "wrap_w2");
        apply(v(H,L,L,Z,H,H,TOP,L,           L,Z,H,Z,32'h5,L,L,Z), "wrap_w3");
        apply(v(H,H,L,Z,L,L,Z,L,             H,TOP,L,Z,32'h5,L,L,Z), "wrap_w4");
        apply(v(H,L,H,32'h6,L,L,Z,L,         L,TOP,L,Z,32'h5,L,L,Z), "wrap_w5");
        apply(v(H,L,L,Z,H,L,Z,L,             L,TOP,H,TOP,32'h6,L,L,Z), "wrap_w6");
        apply(v(H,H,L,Z,L,L,Z,L,             H,Z,L,TOP,32'h6,L,L,Z), "wrap_zero");
        apply(v(H,L,H,32'h7,L,L,Z,L,         L,Z,L,TOP,32'h6,L,L,Z), "loop_rv");
        apply(v(H,L,L,Z,H,H,Z,L,             L,Z,H,Z,32'h7,L,L,Z), "loop_hs");
        apply(v(H,L,L,Z,L,L,Z,L,             H,Z,L,Z,32'h7,L,L,Z), "loop_refetch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
